signal_decay_sweeper: RTL and testbench
=======================================

SIGNAL_DECAY_SWEEPER -- requirements
Module: signal_decay_sweeper

Interface
REQ-001 SHALL have parameter GRID_W, default 160, meaning grid columns swept.
REQ-002 SHALL have parameter GRID_H, default 120, meaning grid rows swept.
REQ-003 SHALL have parameter DECAY_PERIOD, default 4, meaning game ticks between sweeps (legal range >=1).
REQ-004 SHALL have parameter DECAY_STEP, default 1, meaning amount subtracted from each nonzero signal per sweep.
REQ-005 SHALL have port clk, input, 1, meaning the single system clock; all logic on its rising edge.
REQ-006 SHALL have port RESET_SIM, input, 1, meaning reset, asynchronous, active-high.
REQ-007 SHALL have port tick, input, 1, meaning one-cycle game-tick pulse.
REQ-008 SHALL have port enable, input, 1, meaning run permission (tied to ~SETUP_MODE).
REQ-009 SHALL have port pause, input, 1, meaning freeze all state.
REQ-010 SHALL have port stall, input, 1, meaning an ant write owns the environment this cycle (write_flag).
REQ-011 SHALL have ports rd_x/rd_y, output, X_bits/Y_bits, meaning lookup address.
REQ-012 SHALL have port rd_signal, input, SIGNAL_bits, meaning lookup data, valid one cycle after rd_x/rd_y.
REQ-013 SHALL have ports wr_x/wr_y, output, X_bits/Y_bits, plus wr_signal, output, SIGNAL_bits, and wr_en, output, 1, meaning the write port.
REQ-014 SHALL have ports busy, output, 1; sweep_done, output, 1; overrun, output, 1; and sweep_count, output, 16, meaning status.

Function
REQ-015 SHALL implement the states IDLE, RD, WR and DONE.
REQ-016 SHALL hold a period counter; in IDLE, each tick with enable=1 increments it, and when it equals DECAY_PERIOD-1 the block SHALL clear it, zero the cursor and enter RD.
REQ-017 RD SHALL drive rd_x/rd_y = cursor and go to WR next cycle unless stall=1, in which case it stays in RD.
REQ-018 WR SHALL compute wr_signal = rd_signal - DECAY_STEP saturating at 0 and assert wr_en for exactly that cycle, with wr_x/wr_y = cursor, only when rd_signal != 0 and stall=0.
REQ-019 If stall=1 in WR, the block SHALL not write and SHALL return to RD for the same cell, so it re-reads the data because an ant may have changed it.
REQ-020 After WR with no stall, the cursor SHALL advance: x+1; on x=GRID_W-1, x wraps to 0 and y+1; on the last cell (GRID_W-1, GRID_H-1) the state SHALL go to DONE instead of RD.
REQ-021 DONE SHALL pulse sweep_done for one cycle, increment sweep_count (wraps at 2^16) and return to IDLE.
REQ-022 busy SHALL be 1 in RD, WR and DONE.
REQ-023 A tick while busy SHALL be dropped, SHALL not advance the period counter, and SHALL set overrun; overrun is sticky until reset.
REQ-024 enable=0 in any non-IDLE state SHALL abort to IDLE on the next edge without writing, keeping the period counter at 0; sweep_done SHALL not pulse.
REQ-025 pause=1 SHALL hold state, cursor, counters and ignore tick; wr_en and sweep_done SHALL be 0 while paused.
REQ-026 If tick and stall are both high, the tick SHALL be honoured; stall affects only RD and WR.
REQ-027 The pipeline SHALL be two cycles per cell when there is no stall, so a full sweep takes 2*GRID_W*GRID_H+1 cycles.

Reset
REQ-028 RESET_SIM SHALL force IDLE and zero the period counter, cursor, rd_x, rd_y, wr_x, wr_y, wr_signal, wr_en, busy, sweep_done, overrun and sweep_count, asynchronously and independent of clk.

Structure
REQ-029 X_bits, Y_bits and SIGNAL_bits SHALL come from params.sv; the decay_state_t enum SHALL be added to the shared package.
REQ-030 A single sub-module, grid_cursor, SHALL be used: a raster x/y counter with clear, advance and last outputs.

Verification (GRID_W=4, GRID_H=2, DECAY_PERIOD=2, DECAY_STEP=3)
REQ-031 Bench: two ticks, memory all 5 -> 8 writes of value 2 at (0,0)..(3,1) in raster order, one sweep_done, sweep_count=1.
REQ-032 Bench: cell value 2 and cell value 0 -> write of 0 for the value-2 cell; no wr_en for the value-0 cell.
REQ-033 Bench: stall held 3 cycles during WR at (1,0) -> no write there, rd_x=1 re-issued, a single write after stall drops, cursor resumes at (2,0).
REQ-034 Bench: tick during sweep -> overrun=1 stays set and the period count is unaffected; the next sweep needs two further ticks.
REQ-035 Bench: enable=0 at cell (2,1) -> IDLE next cycle, busy=0, no sweep_done, no further writes.
REQ-036 Bench: RESET_SIM asserted mid-WR, between clock edges -> wr_en, busy and sweep_count are 0 immediately.

Source files
------------

// File: rtl/signal_decay_sweeper_pkg.sv
// Shared definitions for the signal decay sweeper: field widths, FSM states
// and the saturating decay helper.
package signal_decay_sweeper_pkg;

  localparam int X_BITS      = 8;
  localparam int Y_BITS      = 7;
  localparam int SIGNAL_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    DONE
  } decay_state_t;

  // Subtract step from value, clamping at zero instead of wrapping.
  function automatic logic [SIGNAL_BITS-1:0] sat_sub(
    input logic [SIGNAL_BITS-1:0] value,
    input int unsigned            step
  );
    if (32'(value) > step) return value - SIGNAL_BITS'(step);
    return '0;
  endfunction

endpackage

// File: rtl/grid_cursor.sv
// Raster-order x/y cursor over a GRID_W x GRID_H grid.
// clear has priority over advance; last flags the final cell of the raster.
module grid_cursor
  import signal_decay_sweeper_pkg::*;
#(
  parameter int GRID_W = 160,
  parameter int GRID_H = 120
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [X_BITS-1:0] x,
  output logic [Y_BITS-1:0] y,
  output logic              last
);

  localparam logic [X_BITS-1:0] X_LAST = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST = Y_BITS'(GRID_H - 1);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Step x across each row, carrying into y; wrap back to the origin after the last cell.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x <= '0;
      y <= '0;
    end else if (clear) begin
      x <= '0;
      y <= '0;
    end else if (advance) begin
      if (x == X_LAST) begin
        x <= '0;
        y <= (y == Y_LAST) ? '0 : y + Y_BITS'(1);
      end else begin
        x <= x + X_BITS'(1);
      end
    end
  end

endmodule

// File: rtl/signal_decay_sweeper.sv
// Periodically sweeps the signal grid and decays every nonzero cell by
// DECAY_STEP. Each cell costs a read cycle and a write cycle; ant writes
// (stall) take priority and force the current cell to be re-read.
module signal_decay_sweeper
  import signal_decay_sweeper_pkg::*;
#(
  parameter int GRID_W       = 160,
  parameter int GRID_H       = 120,
  parameter int DECAY_PERIOD = 4,
  parameter int DECAY_STEP   = 1
) (
  input  logic                   clk,
  input  logic                   RESET_SIM,
  input  logic                   tick,
  input  logic                   enable,
  input  logic                   pause,
  input  logic                   stall,
  output logic [X_BITS-1:0]      rd_x,
  output logic [Y_BITS-1:0]      rd_y,
  input  logic [SIGNAL_BITS-1:0] rd_signal,
  output logic [X_BITS-1:0]      wr_x,
  output logic [Y_BITS-1:0]      wr_y,
  output logic [SIGNAL_BITS-1:0] wr_signal,
  output logic                   wr_en,
  output logic                   busy,
  output logic                   sweep_done,
  output logic                   overrun,
  output logic [15:0]            sweep_count
);

  localparam int PERIOD_BITS = (DECAY_PERIOD > 1) ? $clog2(DECAY_PERIOD) : 1;
  localparam logic [PERIOD_BITS-1:0] PERIOD_LAST = PERIOD_BITS'(DECAY_PERIOD - 1);

  decay_state_t           state;
  logic [PERIOD_BITS-1:0] period_cnt;
  logic [X_BITS-1:0]      cur_x;
  logic [Y_BITS-1:0]      cur_y;
  logic                   cur_last;
  logic                   cur_clear;
  logic                   cur_advance;
  logic                   sweep_start;
  logic                   cell_write;

  // A sweep starts on the tick that completes the decay period.
  assign sweep_start = !pause && enable && tick && (state == IDLE) && (period_cnt == PERIOD_LAST);
  assign cur_clear   = sweep_start;
  // The cursor moves only once a cell's write cycle has finished unstalled.
  assign cur_advance = !pause && enable && !stall && (state == WR);

  grid_cursor #(
    .GRID_W(GRID_W),
    .GRID_H(GRID_H)
  ) u_cursor (
    .clk    (clk),
    .rst    (RESET_SIM),
    .clear  (cur_clear),
    .advance(cur_advance),
    .x      (cur_x),
    .y      (cur_y),
    .last   (cur_last)
  );

  // The write happens in the WR cycle itself, while the registered read data is valid.
  assign cell_write = (state == WR) && !pause && enable && !stall && (rd_signal != '0);

  assign rd_x       = cur_x;
  assign rd_y       = cur_y;
  assign wr_x       = cur_x;
  assign wr_y       = cur_y;
  assign wr_en      = cell_write;
  assign wr_signal  = cell_write ? sat_sub(rd_signal, DECAY_STEP) : '0;
  assign busy       = (state != IDLE);
  assign sweep_done = (state == DONE) && !pause && enable;

  // Sweep sequencer: period counting, per-cell read/write handshake, abort and status.
  always_ff @(posedge clk or posedge RESET_SIM) begin
    if (RESET_SIM) begin
      state       <= IDLE;
      period_cnt  <= '0;
      overrun     <= 1'b0;
      sweep_count <= '0;
    end else if (!pause) begin
      // A tick arriving mid-sweep is lost; remember that it happened.
      if (tick && (state != IDLE)) overrun <= 1'b1;

      if ((state != IDLE) && !enable) begin
        state      <= IDLE;
        period_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (tick && enable) begin
              if (period_cnt == PERIOD_LAST) begin
                period_cnt <= '0;
                state      <= RD;
              end else begin
                period_cnt <= period_cnt + PERIOD_BITS'(1);
              end
            end
          end
          RD: begin
            if (!stall) state <= WR;
          end
          WR: begin
            if (stall)         state <= RD;
            else if (cur_last) state <= DONE;
            else               state <= RD;
          end
          DONE: begin
            sweep_count <= sweep_count + 16'd1;
            state       <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_signal_decay_sweeper.sv
// Directed bench for signal_decay_sweeper on a 4x2 grid, period 2, step 3.
// The bench owns a small registered-read signal memory and logs every write.
module tb_signal_decay_sweeper;

  localparam int W = 4;
  localparam int H = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tick = 1'b0;
  logic       enable = 1'b1;
  logic       pause = 1'b0;
  logic       stall = 1'b0;
  logic [7:0] rd_x;
  logic [6:0] rd_y;
  logic [7:0] rd_signal = 8'd0;
  logic [7:0] wr_x;
  logic [6:0] wr_y;
  logic [7:0] wr_signal;
  logic       wr_en;
  logic       busy;
  logic       sweep_done;
  logic       overrun;
  logic [15:0] sweep_count;

  signal_decay_sweeper #(
    .GRID_W(W), .GRID_H(H), .DECAY_PERIOD(2), .DECAY_STEP(3)
  ) dut (
    .clk(clk), .RESET_SIM(rst), .tick(tick), .enable(enable), .pause(pause),
    .stall(stall), .rd_x(rd_x), .rd_y(rd_y), .rd_signal(rd_signal),
    .wr_x(wr_x), .wr_y(wr_y), .wr_signal(wr_signal), .wr_en(wr_en),
    .busy(busy), .sweep_done(sweep_done), .overrun(overrun),
    .sweep_count(sweep_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [7:0] val;
  } wr_t;

  typedef struct {
    int test;
    int x;
    int y;
    int val;
  } vec_t;

  logic [7:0] mem [W*H];
  wr_t        wq[$];
  int         done_cnt = 0;
  int         total = 0;
  int         bad = 0;
  vec_t       tbl [40];
  int         tbl_n = 0;

  // Environment memory with registered read, plus write/done logging.
  always @(posedge clk) begin
    rd_signal <= mem[int'(rd_y) * W + int'(rd_x)];
    if (wr_en) begin
      mem[int'(wr_y) * W + int'(wr_x)] <= wr_signal;
      wq.push_back('{x: wr_x, y: wr_y, val: wr_signal});
      $display("write x=%0d y=%0d val=%0d", wr_x, wr_y, wr_signal);
    end
    if (sweep_done) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end else begin
      $display("ok   %s = %0d", name, act);
    end
  endtask

  task automatic add(input int t, input int x, input int y, input int v);
    tbl[tbl_n] = '{test: t, x: x, y: y, val: v};
    tbl_n++;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
  endtask

  task automatic fill_mem(input logic [7:0] v);
    for (int i = 0; i < W*H; i++) mem[i] = v;
  endtask

  // Run until busy drops; returns the number of cycles spent busy.
  task automatic wait_idle(input string name, output int c);
    c = 0;
    while (busy && c < 200) begin
      cyc();
      c++;
    end
    if (busy) check({name, " idle timeout"}, 32'(busy), 32'd0);
  endtask

  task automatic wait_cell(input int x, input int y);
    int i;
    for (i = 0; i < 60; i++) begin
      if (busy && int'(rd_x) == x && int'(rd_y) == y) break;
      cyc();
    end
    check($sformatf("reach cell (%0d,%0d)", x, y), 32'(i < 60), 32'd1);
  endtask

  task automatic check_writes(input int t);
    int n = 0;
    for (int i = 0; i < tbl_n; i++) begin
      if (tbl[i].test == t) begin
        if (n < wq.size()) begin
          check($sformatf("t%0d write %0d xyv", t, n),
                {8'(wq[n].x), 8'(wq[n].y), 8'(wq[n].val)},
                {8'(tbl[i].x), 8'(tbl[i].y), 8'(tbl[i].val)});
        end else begin
          check($sformatf("t%0d write %0d present", t, n), 32'd0, 32'd1);
        end
        n++;
      end
    end
    check($sformatf("t%0d write count", t), 32'(wq.size()), 32'(n));
    wq.delete();
  endtask

  int c;
  int d0;

  initial begin
    // Expected write streams, raster order.
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) add(1, x, y, 2);
    add(2, 0, 0, 0);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) if (y > 0 || x > 1) add(2, x, y, 2);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) add(3, x, y, 2);
    for (int y = 0; y < H; y++) for (int x = 0; x < W; x++) if (y == 0 || x < 2) add(5, x, y, 2);

    fill_mem(8'd5);
    cyc(); cyc();
    check("reset busy", 32'(busy), 0);
    check("reset wr_en", 32'(wr_en), 0);
    check("reset sweep_count", 32'(sweep_count), 0);
    check("reset overrun", 32'(overrun), 0);
    check("reset rd_x", 32'(rd_x), 0);
    rst = 1'b0;
    cyc();

    // Basic sweep of an all-5 grid.
    pulse_tick();
    check("t1 idle after first tick", 32'(busy), 0);
    pulse_tick();
    check("t1 busy after second tick", 32'(busy), 1);
    wait_idle("t1", c);
    check("t1 sweep cycles", 32'(c), 32'(2*W*H+1));
    check("t1 done pulses", 32'(done_cnt), 1);
    check("t1 sweep_count", 32'(sweep_count), 1);
    check("t1 overrun", 32'(overrun), 0);
    check_writes(1);

    // Value 2 cell decays to 0, value 0 cell is skipped; pause mid-write.
    fill_mem(8'd5);
    mem[0] = 8'd2;
    mem[1] = 8'd0;
    pulse_tick();
    pulse_tick();
    wait_cell(2, 0);
    cyc();
    pause = 1'b1;
    tick = 1'b1;
    #1;
    check("t2 paused wr_en", 32'(wr_en), 0);
    cyc(); cyc();
    check("t2 paused rd_x", 32'(rd_x), 2);
    check("t2 paused busy", 32'(busy), 1);
    check("t2 paused overrun", 32'(overrun), 0);
    tick = 1'b0;
    pause = 1'b0;
    #1;
    check("t2 resumed wr_en", 32'(wr_en), 1);
    wait_idle("t2", c);
    check("t2 sweep_count", 32'(sweep_count), 2);
    check_writes(2);

    // Stall held three cycles from the write cycle of (1,0).
    fill_mem(8'd5);
    pulse_tick();
    pulse_tick();
    wait_cell(1, 0);
    cyc();
    stall = 1'b1;
    #1;
    check("t3 stall wr_en c0", 32'(wr_en), 0);
    cyc();
    check("t3 stall rd_x c1", 32'(rd_x), 1);
    check("t3 stall wr_en c1", 32'(wr_en), 0);
    cyc();
    check("t3 stall rd_x c2", 32'(rd_x), 1);
    stall = 1'b0;
    #1;
    check("t3 reread wr_en", 32'(wr_en), 0);
    cyc();
    check("t3 write after stall", {8'(wr_en), wr_x, wr_signal}, {8'd1, 8'd1, 8'd2});
    cyc();
    check("t3 cursor resumes", 32'(rd_x), 2);
    wait_idle("t3", c);
    check("t3 sweep_count", 32'(sweep_count), 3);
    check_writes(3);

    // Tick during a sweep: dropped, flags overrun, period count untouched.
    pulse_tick();
    pulse_tick();
    cyc(); cyc(); cyc();
    pulse_tick();
    check("t4 overrun set", 32'(overrun), 1);
    wait_idle("t4a", c);
    check("t4 overrun sticky", 32'(overrun), 1);
    check("t4 sweep_count", 32'(sweep_count), 4);
    pulse_tick();
    check("t4 one tick not enough", 32'(busy), 0);
    pulse_tick();
    check("t4 second tick starts", 32'(busy), 1);
    wait_idle("t4b", c);
    check("t4 sweep_count again", 32'(sweep_count), 5);
    check("t4 overrun still set", 32'(overrun), 1);
    wq.delete();

    // Abort with enable=0 during the write cycle of (2,1).
    fill_mem(8'd5);
    pulse_tick();
    pulse_tick();
    wait_cell(2, 1);
    cyc();
    d0 = done_cnt;
    enable = 1'b0;
    #1;
    check("t5 abort wr_en", 32'(wr_en), 0);
    cyc();
    check("t5 abort busy", 32'(busy), 0);
    cyc(); cyc(); cyc();
    check("t5 no done pulse", 32'(done_cnt), 32'(d0));
    check("t5 sweep_count held", 32'(sweep_count), 5);
    check_writes(5);
    enable = 1'b1;
    cyc();

    // Asynchronous reset between edges during a write cycle.
    fill_mem(8'd5);
    pulse_tick();
    pulse_tick();
    cyc();
    check("t6 mid write wr_en", 32'(wr_en), 1);
    #3;
    rst = 1'b1;
    #1;
    check("t6 async wr_en", 32'(wr_en), 0);
    check("t6 async busy", 32'(busy), 0);
    check("t6 async sweep_count", 32'(sweep_count), 0);
    check("t6 async overrun", 32'(overrun), 0);
    #2;
    rst = 1'b0;
    cyc();
    check("t6 idle after reset", 32'(busy), 0);
    check("t6 no write logged", 32'(wq.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
